// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-ported word memory between instruction fetch and load/store
// Ports:
//   clk, reset                 clock; asynchronous active-high reset
//   if_req_* / if_resp_*       fetch request handshake and one-cycle response pulse
//   dm_req_* / dm_resp_*       load/store request handshake and one-cycle response pulse
//                              (dm_resp_data is 0 for stores)
//   mem_*                      unified memory port; mem_data_out is valid READ_LATENCY
//                              cycles after mem_address is presented
module memory_arbiter #(
    parameter int XLEN            = 32,
    parameter int READ_LATENCY    = 1,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req_valid,
    output logic            if_req_ready,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_resp_valid,
    output logic [XLEN-1:0] if_resp_data,
    input  logic            dm_req_valid,
    output logic            dm_req_ready,
    input  logic [XLEN-1:0] dm_addr,
    input  logic            dm_write_en,
    input  logic [XLEN-1:0] dm_wdata,
    output logic            dm_resp_valid,
    output logic [XLEN-1:0] dm_resp_data,
    output logic [XLEN-1:0] mem_address,
    output logic            mem_write_en,
    output logic [XLEN-1:0] mem_data_in,
    input  logic [XLEN-1:0] mem_data_out
);
    localparam int CW = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      streak_q, streak_d;
    logic            owner_dm_q, owner_dm_d;
    logic            store_q, store_d;
    logic [XLEN-1:0] mem_address_q, mem_address_d;
    logic [XLEN-1:0] mem_data_in_q, mem_data_in_d;
    logic            mem_write_en_q, mem_write_en_d;
    logic            if_resp_valid_q, if_resp_valid_d;
    logic            dm_resp_valid_q, dm_resp_valid_d;
    logic [XLEN-1:0] if_resp_data_q, if_resp_data_d;
    logic [XLEN-1:0] dm_resp_data_q, dm_resp_data_d;
    logic            grant_if, grant_dm, streak_full;

    always_comb begin
        streak_full     = streak_q == 4'(MAX_DATA_STREAK);
        // data wins ties unless fetch has already waited out a full streak
        grant_dm        = state_q == IDLE && !reset && dm_req_valid && !(if_req_valid && streak_full);
        grant_if        = state_q == IDLE && !reset && if_req_valid && !grant_dm;
        state_d         = state_q;
        cnt_d           = cnt_q;
        streak_d        = streak_q;
        owner_dm_d      = owner_dm_q;
        store_d         = store_q;
        mem_address_d   = mem_address_q;
        mem_data_in_d   = mem_data_in_q;
        mem_write_en_d  = 1'b0;
        if_resp_valid_d = 1'b0;
        dm_resp_valid_d = 1'b0;
        if_resp_data_d  = if_resp_data_q;
        dm_resp_data_d  = dm_resp_data_q;
        if (grant_dm || grant_if) begin
            state_d        = ACCESS;
            cnt_d          = CW'(READ_LATENCY);
            owner_dm_d     = grant_dm;
            store_d        = grant_dm && dm_write_en;
            mem_address_d  = grant_dm ? dm_addr : if_addr;
            mem_data_in_d  = grant_dm ? dm_wdata : mem_data_in_q;
            mem_write_en_d = grant_dm && dm_write_en;
            // a data grant over a waiting fetch can only happen below the limit, so +1 never overshoots
            streak_d       = (grant_dm && if_req_valid) ? streak_q + 4'd1 : 4'd0;
        end else if (state_q == ACCESS) begin
            if (cnt_q == '0) begin
                state_d         = IDLE;
                if_resp_valid_d = !owner_dm_q;
                dm_resp_valid_d = owner_dm_q;
                if_resp_data_d  = owner_dm_q ? if_resp_data_q : mem_data_out;
                dm_resp_data_d  = owner_dm_q ? (store_q ? '0 : mem_data_out) : dm_resp_data_q;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            streak_q        <= '0;
            owner_dm_q      <= 1'b0;
            store_q         <= 1'b0;
            mem_address_q   <= '0;
            mem_data_in_q   <= '0;
            mem_write_en_q  <= 1'b0;
            if_resp_valid_q <= 1'b0;
            dm_resp_valid_q <= 1'b0;
            if_resp_data_q  <= '0;
            dm_resp_data_q  <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            streak_q        <= streak_d;
            owner_dm_q      <= owner_dm_d;
            store_q         <= store_d;
            mem_address_q   <= mem_address_d;
            mem_data_in_q   <= mem_data_in_d;
            mem_write_en_q  <= mem_write_en_d;
            if_resp_valid_q <= if_resp_valid_d;
            dm_resp_valid_q <= dm_resp_valid_d;
            if_resp_data_q  <= if_resp_data_d;
            dm_resp_data_q  <= dm_resp_data_d;
        end
    end

    assign if_req_ready  = grant_if;
    assign dm_req_ready  = grant_dm;
    assign if_resp_valid = if_resp_valid_q;
    assign dm_resp_valid = dm_resp_valid_q;
    assign if_resp_data  = if_resp_data_q;
    assign dm_resp_data  = dm_resp_data_q;
    assign mem_address   = mem_address_q;
    assign mem_write_en  = mem_write_en_q;
    assign mem_data_in   = mem_data_in_q;
endmodule
